// File: rtl/alu_pkg.sv
// Shared definitions for the scratch ALU: operand width and op encodings.
package alu_pkg;
  localparam int ALU_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_NOR  = 3'b101,
    OP_SLTU = 3'b110,
    OP_SLL  = 3'b111
  } alu_op_e;
endpackage

// File: rtl/alu_comb.sv
// Combinational op decode and (WIDTH+1)-bit unsigned arithmetic producing next result and flags.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] c_d,
  output logic             carry_d,
  output logic             zero_d,
  output logic             ovf_d
);
  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH:0]   ea, eb, sum, dif, shl;
  logic [SHW-1:0]   sh;
  alu_op_e          op_e;

  assign ea   = {1'b0, a};
  assign eb   = {1'b0, b};
  assign sum  = ea + eb;
  assign dif  = ea - eb;
  assign sh   = b[SHW-1:0];
  assign op_e = alu_op_e'(op);
  // Top bit of the extended shift is the last bit pushed out of a (0 when sh=0).
  assign shl  = ea << sh;

  always_comb begin
    c_d     = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    case (op_e)
      OP_ADD: begin
        c_d     = sum[WIDTH-1:0];
        carry_d = sum[WIDTH];
        ovf_d   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        c_d     = dif[WIDTH-1:0];
        carry_d = dif[WIDTH];
        ovf_d   = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  c_d = a & b;
      OP_OR:   c_d = a | b;
      OP_XOR:  c_d = a ^ b;
      OP_NOR:  c_d = ~(a | b);
      OP_SLTU: c_d = {{(WIDTH-1){1'b0}}, (ea < eb)};
      OP_SLL: begin
        c_d     = shl[WIDTH-1:0];
        carry_d = shl[WIDTH];
      end
      default: c_d = '0;
    endcase
    zero_d = (c_d == '0);
  end
endmodule

// File: rtl/tmp_alu.sv
// Scratch ALU top: one registered output stage over the combinational datapath.
module tmp_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] c,
  output logic             carry,
  output logic             zero,
  output logic             ovf
);
  logic [WIDTH-1:0] c_d, c_q;
  logic             carry_d, carry_q, zero_d, zero_q, ovf_d, ovf_q;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .a       (a),
    .b       (b),
    .op      (op),
    .c_d     (c_d),
    .carry_d (carry_d),
    .zero_d  (zero_d),
    .ovf_d   (ovf_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q     <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      c_q     <= c_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

  assign c     = c_q;
  assign carry = carry_q;
  assign zero  = zero_q;
  assign ovf   = ovf_q;
endmodule

// File: tb/tb_tmp_alu.sv
// Directed and random checks of tmp_alu against hand values and a bit-serial reference.
module tb_tmp_alu;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a, b;
  logic [2:0] op;
  logic [7:0] c;
  logic       carry, zero, ovf;
  int         checks = 0;
  int         failures = 0;

  tmp_alu #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op),
    .c(c), .carry(carry), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] ec,
                       input logic ecy, input logic ez, input logic eo);
    checks++;
    assert ({c, carry, zero, ovf} === {ec, ecy, ez, eo})
    else begin
      failures++;
      $error("FAIL %s: got c=%h carry=%b zero=%b ovf=%b, expected c=%h carry=%b zero=%b ovf=%b",
             tag, c, carry, zero, ovf, ec, ecy, ez, eo);
    end
  endtask

  // Apply inputs, let one rising edge capture them, sample 1ns later.
  task automatic step(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    op = o; a = x; b = y;
    @(posedge clk);
    #1;
  endtask

  // Returns {ovf, zero, carry, c}; shifts one bit at a time to stay independent of the RTL.
  function automatic logic [10:0] ref_model(input logic [2:0] o, input logic [7:0] x,
                                            input logic [7:0] y);
    logic [8:0] s;
    logic [7:0] r;
    logic       cy, ov;
    r = 8'h00; cy = 1'b0; ov = 1'b0;
    case (o)
      3'b000: begin
        s = {1'b0, x} + {1'b0, y}; r = s[7:0]; cy = s[8];
        ov = (x[7] == y[7]) && (r[7] != x[7]);
      end
      3'b001: begin
        s = {1'b0, x} - {1'b0, y}; r = s[7:0]; cy = (x < y);
        ov = (x[7] != y[7]) && (r[7] != x[7]);
      end
      3'b010: r = x & y;
      3'b011: r = x | y;
      3'b100: r = x ^ y;
      3'b101: r = ~(x | y);
      3'b110: r = (x < y) ? 8'd1 : 8'd0;
      default: begin
        r = x;
        for (int i = 0; i < int'(y[2:0]); i++) begin
          cy = r[7];
          r  = {r[6:0], 1'b0};
        end
      end
    endcase
    return {ov, (r == 8'h00), cy, r};
  endfunction

  initial begin
    logic [10:0] e;
    rst_n = 1'b0; a = 8'd0; b = 8'd0; op = 3'b000;
    #2;
    check("reset_initial", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    step(3'b000, 8'd5, 8'd3);        check("add_5_3",     8'd8,  1'b0, 1'b0, 1'b0);
    step(3'b000, 8'd200, 8'd100);    check("add_wrap",    8'd44, 1'b1, 1'b0, 1'b0);
    step(3'b000, 8'h80, 8'h80);      check("add_80_80",   8'h00, 1'b1, 1'b1, 1'b1);
    step(3'b001, 8'd3, 8'd5);        check("sub_3_5",     8'hFE, 1'b1, 1'b0, 1'b0);
    step(3'b001, 8'd5, 8'd5);        check("sub_5_5",     8'h00, 1'b0, 1'b1, 1'b0);
    step(3'b001, 8'h80, 8'h01);      check("sub_ovf",     8'h7F, 1'b0, 1'b0, 1'b1);
    step(3'b110, 8'h7F, 8'h80);      check("sltu_7f_80",  8'h01, 1'b0, 1'b0, 1'b0);
    step(3'b110, 8'h80, 8'h7F);      check("sltu_80_7f",  8'h00, 1'b0, 1'b1, 1'b0);
    step(3'b010, 8'hF0, 8'h3C);      check("and",         8'h30, 1'b0, 1'b0, 1'b0);
    step(3'b011, 8'hF0, 8'h0C);      check("or",          8'hFC, 1'b0, 1'b0, 1'b0);
    step(3'b100, 8'hFF, 8'h0F);      check("xor",         8'hF0, 1'b0, 1'b0, 1'b0);
    step(3'b101, 8'hF0, 8'h0F);      check("nor",         8'h00, 1'b0, 1'b1, 1'b0);
    step(3'b111, 8'h81, 8'h01);      check("sll_1",       8'h02, 1'b1, 1'b0, 1'b0);
    step(3'b111, 8'h81, 8'hF8);      check("sll_0_hib",   8'h81, 1'b0, 1'b0, 1'b0);
    step(3'b111, 8'h40, 8'h0A);      check("sll_2_hib",   8'h00, 1'b1, 1'b1, 1'b0);

    // Async reset mid-stream: outputs clear before any clock edge.
    step(3'b000, 8'd5, 8'd3);        check("add_pre_rst", 8'd8,  1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check("reset_async", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(3'b000, 8'd5, 8'd3);        check("add_post_rst", 8'd8, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      step(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      e = ref_model(op, a, b);
      check("soak", e[7:0], e[8], e[9], e[10]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
